// File: rtl/mem_stream_reader.sv
// Sequential word-read engine: issues word_count reads, returns {addr,data} in issue order, MEM_LATENCY+1 cycles issue-to-out_valid.
// Downstream stalls throttle issue via credits (inflight + fifo occupancy), so the output FIFO can never overflow.

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end
endmodule

module mem_stream_reader #(
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [31:0]        mem_addr_32,
  output logic               mem_rw,
  output logic               mem_en,
  input  logic [31:0]        mem_data_in_32,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [31:0]        out_addr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, last_addr_q;
  logic [COUNT_W-1:0]  remaining_q;
  logic [MEM_LATENCY-1:0] pipe_vld_q;
  logic [31:0]         pipe_addr_q [MEM_LATENCY];
  logic [CW-1:0]       inflight_q, fifo_count;
  logic [CW:0]         credit_used;
  logic                issue, ret_vld, pop_vld, fifo_empty, accept;
  entry_t              push_dat, head_dat;

  assign pop_vld = out_valid && out_ready;
  assign ret_vld = pipe_vld_q[MEM_LATENCY-1];
  // Credits in use after this cycle's pop; a return only moves a credit from pipe to FIFO.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop_vld};
  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (word_count == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = (credit_used < DEPTH_C);
        if (issue && remaining_q == {{(COUNT_W-1){1'b0}}, 1'b1}) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight_q == '0 && fifo_empty) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_addr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= base_addr & 32'hFFFF_FFFC;
        remaining_q <= word_count;
      end else if (issue) begin
        addr_q      <= addr_q + 32'd4;
        last_addr_q <= addr_q;
        remaining_q <= remaining_q - 1'b1;
      end
      inflight_q     <= inflight_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, ret_vld};
      pipe_vld_q[0]  <= issue;
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign mem_en      = issue;
  assign mem_rw      = 1'b1;
  assign mem_addr_32 = issue ? addr_q : last_addr_q;

  assign push_dat.data = mem_data_in_32;
  assign push_dat.addr = pipe_addr_q[MEM_LATENCY-1];

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_out_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (ret_vld),
    .push_dat (push_dat),
    .pop      (pop_vld),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_dat.data;
  assign out_addr  = head_dat.addr;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory model, scoreboard queue, negedge monitor.
module tb_mem_stream_reader;
  logic        clock, reset, start, busy, done, mem_rw, mem_en, out_valid, out_ready;
  logic [31:0] base_addr, mem_addr_32, mem_data_in_32, out_data, out_addr;
  logic [15:0] word_count;

  int total = 0, bad = 0;
  int pop_cnt = 0, mem_en_cnt = 0, done_cnt = 0, run = 0, max_run = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  mem_stream_reader #(.MEM_LATENCY(1), .FIFO_DEPTH(4), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_addr_32(mem_addr_32),
    .mem_rw(mem_rw), .mem_en(mem_en), .mem_data_in_32(mem_data_in_32),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hABCDABCD;
      32'h4:   return 32'hDEFADEFA;
      32'h8:   return 32'h12341234;
      32'hC:   return 32'h55AA55AA;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // One-cycle-latency memory: sample request at the edge, drive data shortly after.
  always @(posedge clock) begin
    logic        en_s;
    logic [31:0] a_s;
    en_s = mem_en;
    a_s  = mem_addr_32;
    #1;
    if (en_s) mem_data_in_32 = mem_word(a_s);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [31:0] ea, ed;
    if (!reset) begin
      if (mem_en) begin
        mem_en_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got addr %h data %h expected no output", out_addr, out_data);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("out_addr", out_addr, ea);
          check("out_data", out_data, ed);
        end
      end
    end
  end

  task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < maxc) begin
      @(negedge clock); #1;
      k++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL done_timeout: got no done pulse in %0d cycles expected one", maxc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr_32, 0);
    check({tag, "_mem_rw"}, mem_rw, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_addr"}, out_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, d0, p0, k;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    out_ready = 1'b1; mem_data_in_32 = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // 1: basic four-word read
    expect_word(32'h0, 32'hABCDABCD);
    expect_word(32'h4, 32'hDEFADEFA);
    expect_word(32'h8, 32'h12341234);
    expect_word(32'hC, 32'h55AA55AA);
    m0 = mem_en_cnt; d0 = done_cnt; max_run = 0;
    pulse_start(32'h0, 16'd4);
    wait_done(50);
    check("t1_busy_at_done", busy, 0);
    repeat (3) @(posedge clock);
    #1;
    check("t1_mem_en_cnt", mem_en_cnt - m0, 4);
    check("t1_mem_en_run", max_run, 4);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_busy_after", busy, 0);
    check("t1_sb_empty", exp_addr_q.size(), 0);

    // 2: consumer stall limits issue to FIFO depth
    for (int i = 0; i < 16; i++) expect_word(32'(4 * i), mem_word(32'(4 * i)));
    out_ready = 1'b0;
    m0 = mem_en_cnt; p0 = pop_cnt;
    pulse_start(32'h0, 16'd16);
    repeat (20) @(posedge clock);
    #1;
    check("t2_stall_issues", mem_en_cnt - m0, 4);
    check("t2_stall_valid", out_valid, 1);
    check("t2_stall_data", out_data, 32'hABCDABCD);
    check("t2_stall_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    wait_done(200);
    check("t2_mem_en_cnt", mem_en_cnt - m0, 16);
    check("t2_pops", pop_cnt - p0, 16);
    check("t2_sb_empty", exp_addr_q.size(), 0);

    // 3: zero-length request
    m0 = mem_en_cnt; d0 = done_cnt;
    pulse_start(32'h40, 16'd0);
    check("t3_done_hi", done, 1);
    check("t3_busy", busy, 0);
    @(posedge clock); #1;
    check("t3_done_lo", done, 0);
    check("t3_done_pulses", done_cnt - d0, 1);
    check("t3_no_mem_en", mem_en_cnt - m0, 0);

    // 4: address wrap, low base bits ignored
    expect_word(32'hFFFFFFF8, 32'hFFF80007);
    expect_word(32'hFFFFFFFC, 32'hFFFC0003);
    expect_word(32'h00000000, 32'hABCDABCD);
    expect_word(32'h00000004, 32'hDEFADEFA);
    pulse_start(32'hFFFFFFFB, 16'd4);
    wait_done(50);
    check("t4_sb_empty", exp_addr_q.size(), 0);

    // 5: reset mid-transfer
    for (int i = 0; i < 8; i++) expect_word(32'(4 * i), mem_word(32'(4 * i)));
    p0 = pop_cnt;
    pulse_start(32'h0, 16'd8);
    k = 0;
    while (pop_cnt - p0 < 2 && k < 50) begin
      @(negedge clock); #1;
      k++;
    end
    check("t5_two_pops", pop_cnt - p0, 2);
    @(posedge clock); #1;
    reset = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    d0 = done_cnt;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_idle_valid", out_valid, 0);
    m0 = mem_en_cnt;
    expect_word(32'h20, 32'h0020FFDF);
    pulse_start(32'h20, 16'd1);
    wait_done(50);
    check("t5_mem_en_cnt", mem_en_cnt - m0, 1);
    check("t5_sb_empty", exp_addr_q.size(), 0);

    // 6: start while busy is ignored
    expect_word(32'h40, 32'h0040FFBF);
    expect_word(32'h44, 32'h0044FFBB);
    expect_word(32'h48, 32'h0048FFB7);
    expect_word(32'h4C, 32'h004CFFB3);
    out_ready = 1'b0;
    m0 = mem_en_cnt; d0 = done_cnt;
    pulse_start(32'h40, 16'd4);
    pulse_start(32'h100, 16'd2);
    check("t6_busy", busy, 1);
    repeat (3) @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_done(50);
    repeat (4) @(posedge clock);
    #1;
    check("t6_mem_en_cnt", mem_en_cnt - m0, 4);
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_addr_hold", mem_addr_32, 32'h4C);
    check("t6_sb_empty", exp_addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
